// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: collects WIDTH bits (MSB first) framed by
// sin_first and presents each word through a one-deep valid/ready output register.
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_first,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int CW = $clog2(WIDTH);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic             state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic             word_done;
  logic             handshake;
  logic [WIDTH-1:0] word_new;
  logic [WIDTH-1:0] first_load;

  assign word_new   = {shreg_q[WIDTH-2:0], sin};
  assign first_load = {{(WIDTH-1){1'b0}}, sin};
  assign handshake  = dout_valid_q & dout_ready;

  // Framing FSM and shift register
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sin_valid && sin_first) begin
          shreg_d = first_load;
          count_d = CW'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sin_valid) begin
          if (sin_first) begin
            // Early restart: drop the partial word, the new bit opens a fresh one.
            frame_err_d = 1'b1;
            shreg_d     = first_load;
            count_d     = CW'(1);
          end else if (count_q == CW'(WIDTH - 1)) begin
            word_done = 1'b1;
            shreg_d   = word_new;
            count_d   = '0;
            state_d   = ST_IDLE;
          end else begin
            shreg_d = word_new;
            count_d = count_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Output register: a completed word lands only if the buffer is free or
  // is being drained on this same edge; otherwise it is dropped and flagged.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q & ~ovr_clr;
    if (handshake) begin
      dout_valid_d = 1'b0;
    end
    if (word_done) begin
      if (!dout_valid_q || handshake) begin
        dout_d       = word_new;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      shreg_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: directed scenarios plus random traffic,
// with a bit-list reference model feeding a scoreboard queue checked by a monitor.
module tb_sipo_deser;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         sin;
  logic         sin_valid;
  logic         sin_first;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         frame_err;
  logic         overrun;
  logic         ovr_clr;

  sipo_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_first  (sin_first),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int words_seen = 0;

  // Reference model state: expected registered outputs and the bits of the open word.
  logic         m_valid, m_fe, m_ovr;
  logic [W-1:0] m_dout;
  int           bits[$];
  logic [W-1:0] exp_q[$];

  logic         n_valid, n_fe, n_ovr, n_push, n_flush;
  logic [W-1:0] n_dout, n_word;
  int           n_bits[$];

  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next state of the model from the bits/inputs presented this cycle.
  task automatic model_compute();
    logic hs;
    logic complete;
    n_push = 1'b0;
    n_flush = 1'b0;
    n_word = '0;
    complete = 1'b0;
    if (rst) begin
      n_valid = 1'b0; n_fe = 1'b0; n_ovr = 1'b0; n_dout = '0;
      n_bits = {};
      n_flush = 1'b1;
    end else begin
      n_fe = 1'b0;
      n_bits = bits;
      if (sin_valid) begin
        if (sin_first) begin
          if (bits.size() > 0) n_fe = 1'b1;
          n_bits = {};
          n_bits.push_back(int'(sin));
        end else if (n_bits.size() > 0) begin
          n_bits.push_back(int'(sin));
        end
      end
      if (n_bits.size() == W) begin
        for (int i = 0; i < W; i++) n_word = n_word + W'(n_bits[i] << (W - 1 - i));
        complete = 1'b1;
        n_bits = {};
      end
      hs = m_valid && dout_ready;
      n_valid = m_valid && !hs;
      n_dout = m_dout;
      n_ovr = m_ovr && !ovr_clr;
      if (complete) begin
        if (!m_valid || hs) begin
          n_valid = 1'b1;
          n_dout = n_word;
          n_push = 1'b1;
        end else begin
          n_ovr = 1'b1;
        end
      end
    end
  endtask

  task automatic model_commit();
    m_valid = n_valid; m_fe = n_fe; m_ovr = n_ovr; m_dout = n_dout;
    bits = n_bits;
    if (n_flush) exp_q.delete();
    if (n_push) exp_q.push_back(n_word);
  endtask

  // One clock of stimulus; returns 2 time units after the edge with the model updated.
  task automatic step(input logic r, input logic v, input logic f, input logic b,
                      input logic rdy, input logic clr);
    rst = r; sin_valid = v; sin_first = f; sin = b; dout_ready = rdy; ovr_clr = clr;
    model_compute();
    @(posedge clk);
    #1 model_commit();
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic send(input logic [W-1:0] w, input int gap, input logic rdy, input logic last_rdy);
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, (i == W - 1), w[i], (i == 0) ? last_rdy : rdy, 1'b0);
      if (i != 0) idle(gap, rdy);
    end
  endtask

  // Monitor: compares outputs against the model and pops the scoreboard on handshakes.
  always @(negedge clk) begin
    if (mon_en) begin
      check("dout_valid", 32'(dout_valid), 32'(m_valid));
      check("frame_err", 32'(frame_err), 32'(m_fe));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("dout", 32'(dout), 32'(m_dout));
      if (m_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 32'(0), 32'(1));
        end else begin
          check("sb_word", 32'(dout), 32'(exp_q.pop_front()));
          words_seen++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sin_first = 1'b0; dout_ready = 1'b0; ovr_clr = 1'b0;
    m_valid = 1'b0; m_fe = 1'b0; m_ovr = 1'b0; m_dout = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_valid", 32'(dout_valid), 32'h0);
    check("reset_ovr", 32'(overrun), 32'h0);
    mon_en = 1'b1;

    // Word 1011 back to back, consumer always ready.
    send(4'b1011, 0, 1'b1, 1'b1);
    check("w1011_dout", 32'(dout), 32'hB);
    check("w1011_valid", 32'(dout_valid), 32'h1);
    idle(1, 1'b1);
    check("w1011_valid_drop", 32'(dout_valid), 32'h0);

    // Bits without sin_first are ignored in IDLE; then a gapped word.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send(4'b0110, 2, 1'b1, 1'b1);
    check("w0110_dout", 32'(dout), 32'h6);
    check("w0110_fe", 32'(frame_err), 32'h0);
    idle(2, 1'b1);

    // Restart mid-word.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("restart_fe", 32'(frame_err), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_fe_pulse", 32'(frame_err), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("restart_dout", 32'(dout), 32'h3);
    idle(2, 1'b1);

    // Overrun with a stalled consumer, then drain and clear.
    send(4'b1010, 0, 1'b0, 1'b0);
    send(4'b0101, 0, 1'b0, 1'b0);
    check("ovr_dout_held", 32'(dout), 32'hA);
    check("ovr_set", 32'(overrun), 32'h1);
    idle(1, 1'b1);
    check("ovr_drained", 32'(dout_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_cleared", 32'(overrun), 32'h0);

    // Reset mid-word with a pending output.
    send(4'b1111, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_mid_valid", 32'(dout_valid), 32'h0);
    check("rst_mid_dout", 32'(dout), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send(4'b1100, 0, 1'b0, 1'b0);
    check("post_rst_dout", 32'(dout), 32'hC);
    idle(2, 1'b1);

    // Completion coinciding with a handshake.
    send(4'b1001, 0, 1'b0, 1'b0);
    send(4'b0111, 0, 1'b0, 1'b1);
    check("coinc_dout", 32'(dout), 32'h7);
    check("coinc_valid", 32'(dout_valid), 32'h1);
    check("coinc_ovr", 32'(overrun), 32'h0);
    idle(2, 1'b1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 2),
           1'($urandom),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 19) == 0));
    end
    idle(4, 1'b1);
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    check("words_seen_nonzero", 32'(words_seen > 20), 32'h1);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter: WIDTH, default 4, word width in bits; legal range 2..16.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sin  input  1  serial data bit, MSB of each word first.
REQ-005 sin_valid  input  1  sin carries a valid bit this cycle.
REQ-006 sin_first  input  1  qualifies sin as first (MSB) bit of a word; ignored when sin_valid=0.
REQ-007 dout  output  WIDTH  assembled parallel word.
REQ-008 dout_valid  output  1  dout holds an unconsumed word.
REQ-009 dout_ready  input  1  consumer accepts dout this cycle when dout_valid=1.
REQ-010 frame_err  output  1  one-cycle pulse: word restarted before completion.
REQ-011 overrun  output  1  sticky: completed word discarded because output buffer was full.
REQ-012 ovr_clr  input  1  clears overrun.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE (waiting for sin_first) and SHIFT (collecting bits), plus a bit counter of ceil(log2(WIDTH)) bits.
REQ-014 In IDLE, sin_valid=1 with sin_first=1 SHALL load sin into the shift register LSB, set count=1, go to SHIFT.
REQ-015 In IDLE, sin_valid=1 with sin_first=0 SHALL discard the bit with no flag.
REQ-016 In SHIFT, sin_valid=1 with sin_first=0 SHALL shift left and insert sin at LSB, incrementing count; sin_valid=0 SHALL hold all state (gaps of any length allowed).
REQ-017 The first received bit SHALL end in dout[WIDTH-1], the last in dout[0].
REQ-018 When the WIDTH-th bit is accepted, the word SHALL be complete and the FSM SHALL return to IDLE on the same edge.
REQ-019 In SHIFT, sin_valid=1 with sin_first=1 SHALL discard the partial word, pulse frame_err for exactly one cycle, and restart with that bit as count=1, remaining in SHIFT.
REQ-020 A completed word SHALL be written to the output register so that dout/dout_valid reflect it in the cycle following the edge that sampled the last bit (latency 1 cycle after last bit).
REQ-021 A handshake SHALL occur on a rising edge where dout_valid=1 and dout_ready=1; dout_valid SHALL then deassert unless a new word is written on that same edge.
REQ-022 dout and dout_valid SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-023 If a word completes while dout_valid=1 and no handshake occurs on that edge, the new word SHALL be dropped, dout unchanged, and overrun set to 1.
REQ-024 If a word completes on the same edge as a handshake, the new word SHALL be written, dout_valid stays 1, overrun unchanged.
REQ-025 overrun SHALL clear on ovr_clr=1; if set and clear coincide, set SHALL win.
REQ-026 dout_ready while dout_valid=0 SHALL have no effect.

Reset
REQ-027 rst=1 SHALL force FSM to IDLE, count=0, shift register=0, dout=0, dout_valid=0, frame_err=0, overrun=0, overriding all other inputs including mid-word and pending output.
REQ-028 After rst deasserts, the first accepted bit SHALL require sin_first=1.

Verification (WIDTH=4)
REQ-029 Reset, dout_ready=1, sin_valid=1 for 4 cycles with bits 1,0,1,1, sin_first on first -> dout=4'b1011, dout_valid high exactly one cycle, one cycle after 4th bit edge.
REQ-030 Bits 0,1,1,0 with 2 idle cycles (sin_valid=0) between each -> dout=4'b0110, single valid; no frame_err.
REQ-031 Bits 1,1 then sin_first=1 with bits 0,0,1,1 -> frame_err pulses one cycle on the restart edge; dout=4'b0011 only.
REQ-032 dout_ready=0, send 4'b1010 then 4'b0101 -> dout holds 4'b1010, overrun=1; then dout_ready=1 -> handshake; ovr_clr=1 -> overrun=0.
REQ-033 rst=1 after 2 bits of a word, pending dout_valid=1 -> all outputs 0 next cycle; then word 4'b1100 received correctly.
REQ-034 dout_ready=0, word 4'b1001 pending; dout_ready=1 on exact completion edge of word 4'b0111 -> 4'b1001 handshaken, dout=4'b0111 valid next cycle, overrun=0.
